// File: rtl/servo_pkg.sv
// Shared definitions for the servo PWM feedback decoder.
//   CNT_W_DEF    default width of the high/period counters
//   angle field positions of the readback word
//   FSM state encoding of the period measurement controller
package servo_pkg;

   localparam int CNT_W_DEF   = 20;

   localparam int ANGLE_W     = 32;
   localparam int DUTY_LSB    = 0;
   localparam int DUTY_MSB    = 15;
   localparam int VALID_BIT   = 16;
   localparam int TIMEOUT_BIT = 17;
   localparam int DUTY_W      = DUTY_MSB - DUTY_LSB + 1;

   // Deglitch counter width; holds FILTER_LEN-1 for FILTER_LEN up to 15.
   localparam int FILT_CNT_W  = 4;

   typedef enum logic {
      ST_ARM  = 1'b0,
      ST_MEAS = 1'b1
   } fb_state_t;

endpackage

// File: rtl/servo_fb_divider.sv
// Unsigned restoring divider producing a 16-bit quotient.
// Fixed latency: load cycle, 16 iteration cycles, one result cycle
// during which done is high and quotient is valid.
//   clock_clk  in   system clock
//   reset_low  in   asynchronous reset, active low (aborts a divide)
//   start      in   accepted only while not busy
//   dividend   in   CNT_W+16 bits; upper CNT_W bits must be < divisor
//                   for an exact quotient, otherwise quotient clamps to all-ones
//   divisor    in   CNT_W bits
//   busy       out  high from load until the result cycle inclusive
//   done       out  one-cycle result strobe
//   quotient   out  16-bit result, valid while done is high
module servo_fb_divider
   import servo_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic                    clock_clk,
   input  logic                    reset_low,
   input  logic                    start,
   input  logic [CNT_W+DUTY_W-1:0] dividend,
   input  logic [CNT_W-1:0]        divisor,
   output logic                    busy,
   output logic                    done,
   output logic [DUTY_W-1:0]       quotient
);

   localparam logic [4:0] ITER_LAST = 5'(DUTY_W);

   logic [CNT_W-1:0]  rem;
   logic [DUTY_W-1:0] low_bits;   // dividend bits still to be shifted in, MSB first
   logic [CNT_W-1:0]  dvs;
   logic [DUTY_W-1:0] quo;
   logic [4:0]        iter;
   logic              clamp;

   logic [CNT_W:0]    rem_sh;
   logic              take;
   logic [CNT_W-1:0]  rem_sub;

   // The partial remainder stays below the divisor, so after the shift it
   // needs one extra bit; the difference always fits back into CNT_W bits.
   always_comb begin
      rem_sh  = {rem, low_bits[DUTY_W-1]};
      take    = (rem_sh >= {1'b0, dvs});
      rem_sub = rem_sh[CNT_W-1:0] - dvs;
   end

   always_ff @(posedge clock_clk or negedge reset_low) begin
      if (!reset_low) begin
         busy     <= 1'b0;
         iter     <= '0;
         rem      <= '0;
         low_bits <= '0;
         dvs      <= '0;
         quo      <= '0;
         clamp    <= 1'b0;
      end else if (!busy) begin
         if (start) begin
            busy     <= 1'b1;
            iter     <= '0;
            rem      <= dividend[CNT_W+DUTY_W-1:DUTY_W];
            low_bits <= dividend[DUTY_W-1:0];
            dvs      <= divisor;
            quo      <= '0;
            // Quotient would not fit in 16 bits (ratio >= 1 or zero divisor).
            clamp    <= (dividend[CNT_W+DUTY_W-1:DUTY_W] >= divisor);
         end
      end else if (iter != ITER_LAST) begin
         rem      <= take ? rem_sub : rem_sh[CNT_W-1:0];
         low_bits <= {low_bits[DUTY_W-2:0], 1'b0};
         quo      <= {quo[DUTY_W-2:0], take};
         iter     <= iter + 1'b1;
      end else begin
         busy     <= 1'b0;
      end
   end

   assign done     = busy && (iter == ITER_LAST);
   assign quotient = clamp ? '1 : quo;

endmodule

// File: rtl/servo_feedback_decoder.sv
// Decodes the servo's PWM position-feedback line into a duty-cycle angle word.
// The input is synchronised, deglitched, and its filtered high time and
// period are measured in clock cycles; duty = high/period as unsigned Q0.16.
//   clock_clk      in   system clock
//   reset_low      in   asynchronous reset, active low
//   pwm_response   in   raw feedback PWM, asynchronous to clock_clk
//   angle          out  [15:0] duty Q0.16, [16] valid, [17] timeout, [31:18] 0
//   sample_strobe  out  one-cycle pulse when the duty field is updated
module servo_feedback_decoder
   import servo_pkg::*;
#(
   parameter int CNT_W          = CNT_W_DEF,
   parameter int FILTER_LEN     = 4,
   parameter int MIN_PERIOD     = 100,
   parameter int TIMEOUT_CYCLES = 200000
) (
   input  logic               clock_clk,
   input  logic               reset_low,
   input  logic               pwm_response,
   output logic [ANGLE_W-1:0] angle,
   output logic               sample_strobe
);

   localparam logic [FILT_CNT_W-1:0] FILT_LAST = FILT_CNT_W'(FILTER_LEN - 1);
   localparam logic [CNT_W-1:0]      MIN_P     = CNT_W'(MIN_PERIOD);
   localparam logic [CNT_W-1:0]      TO_LIMIT  = CNT_W'(TIMEOUT_CYCLES);

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == '1) ? v : v + 1'b1;
   endfunction

   logic                  sync_p0, sync_p1;
   logic                  filt;
   logic [FILT_CNT_W-1:0] fcnt;
   logic                  differ, toggle, rise_evt, fall_evt;

   fb_state_t             state, state_nxt;
   logic [CNT_W-1:0]      period_cnt, high_cnt;
   logic                  fall_seen;
   logic                  timeout_hit;
   logic                  cnt_start, cnt_run, fall_latch, meas_ok, to_fire;

   logic                  meas_vld_p0, load_meas;
   logic [CNT_W-1:0]      high_p0, period_p0;

   logic                  div_busy, div_done;
   logic [DUTY_W-1:0]     div_q;

   logic [DUTY_W-1:0]     duty;
   logic                  valid_flag, timeout_flag;

   // ---- stage: synchroniser and deglitch filter ----
   // The filter counts consecutive samples that disagree with the filtered
   // level; rise/fall events fire on the same edge the level flips, so the
   // measurement logic sees them without an extra register stage.
   assign differ   = (sync_p1 != filt);
   assign toggle   = differ && (fcnt == FILT_LAST);
   assign rise_evt = toggle &&  sync_p1;
   assign fall_evt = toggle && !sync_p1;

   always_ff @(posedge clock_clk or negedge reset_low) begin
      if (!reset_low) begin
         sync_p0 <= 1'b0;
         sync_p1 <= 1'b0;
         filt    <= 1'b0;
         fcnt    <= '0;
      end else begin
         sync_p0 <= pwm_response;
         sync_p1 <= sync_p0;
         if (!differ) begin
            fcnt <= '0;
         end else if (toggle) begin
            filt <= sync_p1;
            fcnt <= '0;
         end else begin
            fcnt <= fcnt + 1'b1;
         end
      end
   end

   // ---- stage: measurement FSM and counters ----
   assign timeout_hit = (state == ST_MEAS) && (period_cnt >= TO_LIMIT);

   always_ff @(posedge clock_clk or negedge reset_low) begin
      if (!reset_low) begin
         state <= ST_ARM;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_ARM:  if (rise_evt)    state_nxt = ST_MEAS;
         ST_MEAS: if (timeout_hit) state_nxt = ST_ARM;
         default:                  state_nxt = ST_ARM;
      endcase
   end

   // Timeout wins over a coincident edge. A rise always restarts the period
   // count; it only yields a measurement if the period was long enough and
   // a fall was seen inside it.
   always_comb begin
      cnt_start  = 1'b0;
      cnt_run    = 1'b0;
      fall_latch = 1'b0;
      meas_ok    = 1'b0;
      to_fire    = 1'b0;
      case (state)
         ST_ARM: begin
            cnt_start = rise_evt;
         end
         ST_MEAS: begin
            if (timeout_hit) begin
               to_fire = 1'b1;
            end else if (rise_evt) begin
               cnt_start = 1'b1;
               meas_ok   = fall_seen && (period_cnt >= MIN_P);
            end else begin
               cnt_run    = 1'b1;
               fall_latch = fall_evt;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clock_clk or negedge reset_low) begin
      if (!reset_low) begin
         period_cnt <= '0;
         high_cnt   <= '0;
         fall_seen  <= 1'b0;
      end else if (cnt_start) begin
         period_cnt <= {{(CNT_W-1){1'b0}}, 1'b1};
         fall_seen  <= 1'b0;
      end else if (cnt_run) begin
         period_cnt <= sat_inc(period_cnt);
         if (fall_latch) begin
            high_cnt  <= period_cnt;
            fall_seen <= 1'b1;
         end
      end else if (to_fire) begin
         period_cnt <= '0;
         fall_seen  <= 1'b0;
      end
   end

   // ---- stage: measurement latch / divider start ----
   // A measurement arriving while a divide is pending or running is dropped.
   assign load_meas = meas_ok && !div_busy && !meas_vld_p0;

   always_ff @(posedge clock_clk or negedge reset_low) begin
      if (!reset_low) begin
         meas_vld_p0 <= 1'b0;
      end else begin
         meas_vld_p0 <= load_meas;
      end
   end

   always_ff @(posedge clock_clk) begin
      if (load_meas) begin
         high_p0   <= high_cnt;
         period_p0 <= period_cnt;
      end
   end

   servo_fb_divider #(
      .CNT_W (CNT_W)
   ) u_divider (
      .clock_clk (clock_clk),
      .reset_low (reset_low),
      .start     (meas_vld_p0),
      .dividend  ({high_p0, {DUTY_W{1'b0}}}),
      .divisor   (period_p0),
      .busy      (div_busy),
      .done      (div_done),
      .quotient  (div_q)
   );

   // ---- stage: angle register ----
   // Timeout is applied after the result update so it wins if both coincide.
   always_ff @(posedge clock_clk or negedge reset_low) begin
      if (!reset_low) begin
         duty          <= '0;
         valid_flag    <= 1'b0;
         timeout_flag  <= 1'b0;
         sample_strobe <= 1'b0;
      end else begin
         sample_strobe <= div_done;
         if (div_done) begin
            duty         <= div_q;
            valid_flag   <= 1'b1;
            timeout_flag <= 1'b0;
         end
         if (to_fire) begin
            valid_flag   <= 1'b0;
            timeout_flag <= 1'b1;
         end
      end
   end

   always_comb begin
      angle                    = '0;
      angle[DUTY_MSB:DUTY_LSB] = duty;
      angle[VALID_BIT]         = valid_flag;
      angle[TIMEOUT_BIT]       = timeout_flag;
   end

endmodule

// File: tb/tb_servo_feedback_decoder.sv
// Bench for servo_feedback_decoder: directed PWM patterns plus random
// periods, checked against a duty/latency model of the decoder.
module tb_servo_feedback_decoder;

   localparam int FL  = 4;
   localparam int MINP = 100;
   localparam int TO  = 3000;
   localparam int LAT = 2 + FL + 18;

   logic        clk   = 1'b0;
   logic        rst_n = 1'b1;
   logic        pwm   = 1'b0;
   logic [31:0] angle;
   logic        strobe;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;
   int strobe_cnt = 0;
   int last_strobe_cyc = 0;
   int dbl = 0;
   logic prev_strobe = 1'b0;

   // Reference model state
   bit          armed;
   int          prev_h, prev_p;
   logic [15:0] m_duty;
   logic        m_valid, m_timeout;

   servo_feedback_decoder #(
      .CNT_W          (20),
      .FILTER_LEN     (FL),
      .MIN_PERIOD     (MINP),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .clock_clk     (clk),
      .reset_low     (rst_n),
      .pwm_response  (pwm),
      .angle         (angle),
      .sample_strobe (strobe)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (strobe) begin
         strobe_cnt      <= strobe_cnt + 1;
         last_strobe_cyc <= cyc;
         if (prev_strobe) dbl <= dbl + 1;
      end
      prev_strobe <= strobe;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, required finish before 2000000");
      $fatal(1, "watchdog");
   end

   function automatic logic [15:0] ref_duty(input int h, input int p);
      longint unsigned q;
      if (h >= p) return 16'hFFFF;
      q = (longint'(h) * 65536) / longint'(p);
      return q[15:0];
   endfunction

   function automatic logic [31:0] exp_angle();
      return {14'b0, m_timeout, m_valid, m_duty};
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      armed     = 1'b0;
      prev_h    = 0;
      prev_p    = 0;
      m_duty    = '0;
      m_valid   = 1'b0;
      m_timeout = 1'b0;
   endtask

   // Checks the outcome of the rise at cycle rc that closed the previous period.
   task automatic close_check(input string tag, input bit expect_s, input int n0, input int rc);
      if (expect_s) begin
         m_duty    = ref_duty(prev_h, prev_p);
         m_valid   = 1'b1;
         m_timeout = 1'b0;
         check({tag, "_strobes"}, strobe_cnt - n0, 1);
         check({tag, "_latency"}, last_strobe_cyc - rc, LAT);
      end else begin
         check({tag, "_strobes"}, strobe_cnt - n0, 0);
      end
      check({tag, "_angle"}, angle, exp_angle());
   endtask

   function automatic bit closes_valid();
      return armed && (prev_p >= MINP) && (prev_h > 0) && (prev_h < prev_p);
   endfunction

   // One PWM period: high for h cycles (optional 2-cycle low glitch at
   // offset g inside the high phase), low for p-h cycles.
   task automatic pwm_period(input string tag, input int h, input int p, input int g);
      int n0;
      int rc;
      bit expect_s;
      n0       = strobe_cnt;
      rc       = 0;
      expect_s = closes_valid();
      for (int i = 0; i < p; i++) begin
         @(negedge clk);
         pwm = (i < h) && !(g != 0 && i >= g && i < g + 2);
         if (i == 0) rc = cyc;
      end
      close_check(tag, expect_s, n0, rc);
      armed  = 1'b1;
      prev_h = h;
      prev_p = p;
   endtask

   initial begin
      int n0;
      int rc;
      int h;
      int p;
      bit expect_s;

      model_reset();

      // Reset held: outputs stay zero while the input toggles
      #1 rst_n = 1'b0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         pwm = ~pwm;
         #1;
         check("rst_angle", angle, 32'h0);
         check("rst_strobe", {31'b0, strobe}, 32'h0);
      end
      @(negedge clk);
      pwm = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (20) @(negedge clk);
      check("post_rst_angle", angle, 32'h0);

      // 25% duty, 1000-cycle period
      for (int k = 0; k < 4; k++) pwm_period("p250", 250, 1000, 0);

      // Glitch inside a 50% high phase must be filtered out
      pwm_period("glitch", 500, 1000, 200);
      pwm_period("glitch", 500, 1000, 200);

      // Short periods rejected; MIN_PERIOD boundary
      for (int k = 0; k < 3; k++) pwm_period("p50", 20, 50, 0);
      pwm_period("p99", 10, 99, 0);
      pwm_period("p100", 10, 100, 0);
      pwm_period("p100", 10, 100, 0);

      // Near-full duty, then timeout with input stuck high
      pwm_period("p995", 995, 1000, 0);
      pwm_period("p995", 995, 1000, 0);
      n0       = strobe_cnt;
      expect_s = closes_valid();
      @(negedge clk);
      pwm = 1'b1;
      rc  = cyc;
      repeat (LAT + 10) @(negedge clk);
      close_check("stuck_close", expect_s, n0, rc);
      for (int i = 0; i < TO + 200; i++) begin
         if (angle[17]) break;
         @(negedge clk);
      end
      m_valid   = 1'b0;
      m_timeout = 1'b1;
      armed     = 1'b0;
      check("timeout_angle", angle, exp_angle());
      @(negedge clk);
      pwm = 1'b0;
      repeat (200) @(negedge clk);
      check("timeout_hold", angle, exp_angle());
      pwm_period("recover", 250, 1000, 0);
      pwm_period("recover", 250, 1000, 0);

      // Reset in the middle of a divide
      n0 = strobe_cnt;
      @(negedge clk);
      pwm = 1'b1;
      rc  = cyc;
      for (int i = 0; i < 40 && cyc < rc + 11; i++) @(negedge clk);
      rst_n = 1'b0;
      pwm   = 1'b0;
      #1;
      check("async_rst_angle", angle, 32'h0);
      check("async_rst_strobe", {31'b0, strobe}, 32'h0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      repeat (40) @(negedge clk);
      check("abort_strobes", strobe_cnt - n0, 0);
      check("abort_angle", angle, 32'h0);
      pwm_period("after_rst", 300, 800, 0);
      pwm_period("after_rst", 300, 800, 0);

      // Random periods and duties
      for (int k = 0; k < 8; k++) begin
         p = int'($urandom_range(1200, 200));
         h = int'($urandom_range(p - 10, 10));
         pwm_period("rand", h, p, 0);
      end
      pwm_period("rand_close", 100, 400, 0);

      check("no_back_to_back", dbl, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
